// File: rtl/cnn_layer_accel_octo_pkg.sv
// Shared types and constants for the cnn_layer_accel_octo input scheduler.
// Sequence words are {RM, RST, P, seq[9:0]}.
package cnn_layer_accel_octo_pkg;

  localparam int C_SEQ_DATA_WIDTH_DEF = 13;

  localparam int SEQ_RM_BIT  = 12;
  localparam int SEQ_RST_BIT = 11;
  localparam int SEQ_P_BIT   = 10;
  localparam int SEQ_IDX_MSB = 9;
  localparam int SEQ_IDX_LSB = 0;

  // One-hot tag carried alongside each beat in the output register
  localparam logic [1:0] TAG_SEQ = 2'b01;
  localparam logic [1:0] TAG_PIX = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_NEW_MAP = 3'd1,
    ST_GAP0    = 3'd2,
    ST_SEQ     = 3'd3,
    ST_GAP1    = 3'd4,
    ST_PIX     = 3'd5,
    ST_DONE    = 3'd6
  } sched_state_t;

  function automatic logic [C_SEQ_DATA_WIDTH_DEF-1:0] seq_pack(
    input logic       rm,
    input logic       rst_f,
    input logic       p,
    input logic [9:0] idx
  );
    logic [C_SEQ_DATA_WIDTH_DEF-1:0] w;
    w = '0;
    w[SEQ_RM_BIT]  = rm;
    w[SEQ_RST_BIT] = rst_f;
    w[SEQ_P_BIT]   = p;
    w[SEQ_IDX_MSB:SEQ_IDX_LSB] = idx;
    return w;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_octo_out_reg.sv
// One-entry valid/ready output register holding a data word and a one-hot tag.
// The entry drains when the ready line selected by its tag is high.
module cnn_layer_accel_octo_out_reg
  import cnn_layer_accel_octo_pkg::*;
#(
  parameter int C_WIDTH = 16
) (
  input  logic               clk_500MHz,
  input  logic               rst,
  input  logic               load,
  input  logic [C_WIDTH-1:0] load_data,
  input  logic [1:0]         load_tag,
  input  logic [1:0]         tag_rdy,
  output logic [C_WIDTH-1:0] data,
  output logic               valid,
  output logic [1:0]         tag,
  output logic               consume
);

  assign consume = valid && ((tag & tag_rdy) != 2'b00);

  always_ff @(posedge clk_500MHz) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
      tag   <= 2'b00;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
      tag   <= load_tag;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cnn_layer_accel_octo_input_sched.sv
// Input scheduler: pulses new_map, then streams sequence words followed by
// pixels onto the shared datain bus, never mixing the two tagged streams.
//
// state   | meaning
// IDLE    | waiting for start; cfg counts sampled on start
// NEW_MAP | new_map pulse to the accelerator
// GAP0    | dead cycle before the sequence phase
// SEQ     | forward sequence words, tag seq
// GAP1    | dead cycle between phases
// PIX     | forward pixels, tag pixel
// DONE    | one-cycle completion pulse
module cnn_layer_accel_octo_input_sched
  import cnn_layer_accel_octo_pkg::*;
#(
  parameter int C_PIXEL_WIDTH    = 16,
  parameter int C_SEQ_DATA_WIDTH = C_SEQ_DATA_WIDTH_DEF,
  parameter int C_CNT_WIDTH      = 16
) (
  input  logic                        clk_500MHz,
  input  logic                        rst,
  input  logic                        start,
  input  logic [C_CNT_WIDTH-1:0]      num_seq_words_cfg,
  input  logic [C_CNT_WIDTH-1:0]      num_pixels_cfg,
  output logic                        busy,
  output logic                        done,
  input  logic [C_SEQ_DATA_WIDTH-1:0] seq_src_data,
  input  logic                        seq_src_valid,
  output logic                        seq_src_rdy,
  input  logic [C_PIXEL_WIDTH-1:0]    pix_src_data,
  input  logic                        pix_src_valid,
  output logic                        pix_src_rdy,
  output logic                        new_map,
  output logic [C_PIXEL_WIDTH-1:0]    datain,
  output logic                        datain_valid,
  output logic                        seq_datain_tag,
  input  logic                        seq_datain_rdy,
  output logic                        pixel_datain_tag,
  input  logic                        pixel_datain_rdy
);

  sched_state_t state, state_nx;

  logic [C_CNT_WIDTH-1:0]   rem_seq, rem_pix;
  logic                     reg_free, seq_acc, pix_acc, load;
  logic [C_PIXEL_WIDTH-1:0] load_data;
  logic [1:0]               load_tag;
  logic [C_PIXEL_WIDTH-1:0] out_data;
  logic                     out_valid, out_consume;
  logic [1:0]               out_tag;

  // Source ready follows accelerator ready combinationally so the single
  // entry can be refilled in the same cycle it drains.
  assign reg_free    = !out_valid || out_consume;
  assign seq_src_rdy = (state == ST_SEQ) && (rem_seq != '0) && reg_free;
  assign pix_src_rdy = (state == ST_PIX) && (rem_pix != '0) && reg_free;
  assign seq_acc     = seq_src_valid && seq_src_rdy;
  assign pix_acc     = pix_src_valid && pix_src_rdy;
  assign load        = seq_acc || pix_acc;
  assign load_data   = seq_acc ? C_PIXEL_WIDTH'(seq_src_data) : pix_src_data;
  assign load_tag    = seq_acc ? TAG_SEQ : TAG_PIX;

  cnn_layer_accel_octo_out_reg #(
    .C_WIDTH (C_PIXEL_WIDTH)
  ) u_out_reg (
    .clk_500MHz (clk_500MHz),
    .rst        (rst),
    .load       (load),
    .load_data  (load_data),
    .load_tag   (load_tag),
    .tag_rdy    ({pixel_datain_rdy, seq_datain_rdy}),
    .data       (out_data),
    .valid      (out_valid),
    .tag        (out_tag),
    .consume    (out_consume)
  );

  assign datain           = out_data;
  assign datain_valid     = out_valid;
  assign seq_datain_tag   = out_valid && ((out_tag & TAG_SEQ) != 2'b00);
  assign pixel_datain_tag = out_valid && ((out_tag & TAG_PIX) != 2'b00);

  always_ff @(posedge clk_500MHz) begin
    if (rst) begin
      state   <= ST_IDLE;
      rem_seq <= '0;
      rem_pix <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && start) begin
        rem_seq <= num_seq_words_cfg;
        rem_pix <= num_pixels_cfg;
      end else begin
        if (seq_acc) rem_seq <= rem_seq - C_CNT_WIDTH'(1);
        if (pix_acc) rem_pix <= rem_pix - C_CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    new_map  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = ST_NEW_MAP;
      end
      ST_NEW_MAP: begin
        new_map  = 1'b1;
        state_nx = ST_GAP0;
      end
      ST_GAP0: state_nx = ST_SEQ;
      ST_SEQ:  if (rem_seq == '0 && reg_free) state_nx = ST_GAP1;
      ST_GAP1: state_nx = ST_PIX;
      ST_PIX:  if (rem_pix == '0 && reg_free) state_nx = ST_DONE;
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cnn_layer_accel_octo_input_sched.sv
// Directed bench for the octo input scheduler: table of map loads plus a
// hand-written reset-mid-stream sequence.
module tb_cnn_layer_accel_octo_input_sched;
  import cnn_layer_accel_octo_pkg::*;

  localparam int PW = 16;
  localparam int SW = 13;
  localparam int CW = 16;

  logic          clk_500MHz = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_seq_words_cfg, num_pixels_cfg;
  logic          busy, done;
  logic [SW-1:0] seq_src_data;
  logic          seq_src_valid, seq_src_rdy;
  logic [PW-1:0] pix_src_data;
  logic          pix_src_valid, pix_src_rdy;
  logic          new_map;
  logic [PW-1:0] datain;
  logic          datain_valid;
  logic          seq_datain_tag, seq_datain_rdy;
  logic          pixel_datain_tag, pixel_datain_rdy;

  cnn_layer_accel_octo_input_sched #(
    .C_PIXEL_WIDTH    (PW),
    .C_SEQ_DATA_WIDTH (SW),
    .C_CNT_WIDTH      (CW)
  ) dut (
    .clk_500MHz        (clk_500MHz),
    .rst               (rst),
    .start             (start),
    .num_seq_words_cfg (num_seq_words_cfg),
    .num_pixels_cfg    (num_pixels_cfg),
    .busy              (busy),
    .done              (done),
    .seq_src_data      (seq_src_data),
    .seq_src_valid     (seq_src_valid),
    .seq_src_rdy       (seq_src_rdy),
    .pix_src_data      (pix_src_data),
    .pix_src_valid     (pix_src_valid),
    .pix_src_rdy       (pix_src_rdy),
    .new_map           (new_map),
    .datain            (datain),
    .datain_valid      (datain_valid),
    .seq_datain_tag    (seq_datain_tag),
    .seq_datain_rdy    (seq_datain_rdy),
    .pixel_datain_tag  (pixel_datain_tag),
    .pixel_datain_rdy  (pixel_datain_rdy)
  );

  always #5 clk_500MHz = ~clk_500MHz;

  int n_checks = 0;
  int n_fail   = 0;
  int seq_sent, pix_sent;
  bit start_issued;

  logic [23:0] outs;
  assign outs = {busy, done, new_map, datain_valid, seq_datain_tag, pixel_datain_tag,
                 seq_src_rdy, pix_src_rdy, datain};

  typedef struct {
    int n_seq;
    int n_pix;
    int bp;
    int bub;
    int exp_done;
    bit start_in_pix;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] seq_word(input int k);
    logic [31:0] kk;
    kk = k * 37 + 11;
    return seq_pack(kk[0], kk[1], kk[2], kk[12:3] ^ 10'h2A5);
  endfunction

  function automatic logic [PW-1:0] pix_word(input int k);
    logic [31:0] v;
    v = (k * 32'h0000_0101) ^ 32'h0000_5A3C;
    return v[15:0];
  endfunction

  task automatic drive_rand(input int bp, input int bub);
    seq_datain_rdy   = ($urandom_range(99) >= bp);
    pixel_datain_rdy = ($urandom_range(99) >= bp);
    seq_src_valid    = ($urandom_range(99) >= bub);
    pix_src_valid    = ($urandom_range(99) >= bub);
    seq_src_data     = seq_word(seq_sent);
    pix_src_data     = pix_word(pix_sent);
  endtask

  // rst_after_pix > 0: assert reset once that many pixel beats have drained.
  task automatic run_load(input int n_seq, input int n_pix, input int bp, input int bub,
                          input int exp_done, input bit start_in_pix, input int rst_after_pix);
    int cyc, seq_beats, pix_beats, done_cnt, done_at, nm_cnt, nm_at, first_seq, first_pix;
    int bad_order, bad_stab, bad_busy, bad_rdy, bad_gap, budget;
    bit det, fin, s_acc, p_acc, cons, prev_hold, prev_st, prev_pt;
    logic [PW-1:0] prev_data;
    cyc = 0; seq_beats = 0; pix_beats = 0; done_cnt = 0; done_at = -1;
    nm_cnt = 0; nm_at = -1; first_seq = -1; first_pix = -1;
    bad_order = 0; bad_stab = 0; bad_busy = 0; bad_rdy = 0; bad_gap = 0;
    prev_hold = 0; prev_st = 0; prev_pt = 0; prev_data = '0; fin = 0;
    seq_sent = 0; pix_sent = 0; start_issued = 0;
    det = (bp == 0 && bub == 0);
    budget = (n_seq + n_pix) * 20 + 40;

    @(posedge clk_500MHz); #1;
    num_seq_words_cfg = CW'(n_seq);
    num_pixels_cfg    = CW'(n_pix);
    start = 1'b1;
    drive_rand(bp, bub);
    @(posedge clk_500MHz); #1;
    start = 1'b0;
    // cfg must have been captured at start; scribble over it
    num_seq_words_cfg = '1;
    num_pixels_cfg    = '1;

    while (!fin) begin
      @(negedge clk_500MHz);
      cyc++;
      if (new_map) begin nm_cnt++; nm_at = cyc; end
      if (!busy) bad_busy++;
      if (pix_src_rdy && (seq_src_rdy || seq_beats < n_seq)) bad_rdy++;
      if (seq_src_rdy && seq_sent >= n_seq) bad_rdy++;
      if (pix_src_rdy && pix_sent >= n_pix) bad_rdy++;
      if (datain_valid && (seq_datain_tag == pixel_datain_tag)) bad_order++;
      if (!datain_valid && (seq_datain_tag || pixel_datain_tag)) bad_order++;
      if (prev_hold && !(datain_valid && datain == prev_data &&
                         seq_datain_tag == prev_st && pixel_datain_tag == prev_pt)) bad_stab++;
      s_acc = seq_src_valid && seq_src_rdy;
      p_acc = pix_src_valid && pix_src_rdy;
      cons  = datain_valid && ((seq_datain_tag && seq_datain_rdy) ||
                               (pixel_datain_tag && pixel_datain_rdy));
      prev_hold = datain_valid && !cons;
      prev_data = datain;
      prev_st   = seq_datain_tag;
      prev_pt   = pixel_datain_tag;
      if (cons && seq_datain_tag) begin
        if (seq_beats == 0) first_seq = cyc;
        chk("seq_beat_data", {16'h0, datain}, {19'h0, seq_word(seq_beats)});
        if (pix_beats != 0) bad_order++;
        seq_beats++;
      end
      if (cons && pixel_datain_tag) begin
        if (pix_beats == 0) first_pix = cyc;
        chk("pix_beat_data", {16'h0, datain}, {16'h0, pix_word(pix_beats)});
        pix_beats++;
      end
      if (det && cyc == 4 + n_seq && (datain_valid || seq_datain_tag || pixel_datain_tag))
        bad_gap++;
      if (done) begin done_cnt++; done_at = cyc; end
      if (rst_after_pix > 0 && pix_beats >= rst_after_pix) break;
      if (done || cyc > budget) fin = 1;
      @(posedge clk_500MHz); #1;
      if (s_acc) seq_sent++;
      if (p_acc) pix_sent++;
      start = start_in_pix && !start_issued && pix_beats > 0 && pix_beats == n_pix / 2;
      if (start) start_issued = 1;
      drive_rand(bp, bub);
    end

    if (rst_after_pix > 0) begin
      @(posedge clk_500MHz); #1;
      rst = 1'b1;
      @(posedge clk_500MHz); #1;
      rst = 1'b0;
      @(negedge clk_500MHz);
      chk("outputs_zero_after_mid_rst", {8'h0, outs}, 32'h0);
      for (int i = 0; i < 20; i++) begin
        if (done) done_cnt++;
        @(negedge clk_500MHz);
      end
      chk("no_done_after_mid_rst", done_cnt, 0);
      chk("idle_after_mid_rst", {31'h0, busy}, 32'h0);
      return;
    end

    chk("new_map_count", nm_cnt, 1);
    chk("new_map_cycle", nm_at, 1);
    chk("seq_beat_count", seq_beats, n_seq);
    chk("pix_beat_count", pix_beats, n_pix);
    chk("done_count", done_cnt, 1);
    chk("tag_exclusive_order", bad_order, 0);
    chk("stall_stability", bad_stab, 0);
    chk("busy_through_load", bad_busy, 0);
    chk("src_rdy_gating", bad_rdy, 0);
    if (det) begin
      chk("done_cycle", done_at, exp_done);
      chk("gap1_no_valid", bad_gap, 0);
      if (n_seq > 0) chk("first_seq_cycle", first_seq, 4);
      if (n_pix > 0) chk("first_pix_cycle", first_pix, n_seq + 6);
    end
    @(posedge clk_500MHz); #1;
    drive_rand(bp, bub);
    @(negedge clk_500MHz);
    chk("idle_after_done", {30'h0, busy, done}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    num_seq_words_cfg = '0; num_pixels_cfg = '0;
    seq_src_data = '0; seq_src_valid = 1'b1; pix_src_data = '0; pix_src_valid = 1'b1;
    seq_datain_rdy = 1'b1; pixel_datain_rdy = 1'b1;
    seq_sent = 0; pix_sent = 0; start_issued = 0;

    //          n_seq n_pix bp  bub done start_in_pix
    vecs[0] = '{8,    100,  0,  0,  114, 1'b0};
    vecs[1] = '{0,    5,    0,  0,  11,  1'b0};
    vecs[2] = '{3,    0,    0,  0,  9,   1'b0};
    vecs[3] = '{0,    0,    0,  0,  6,   1'b0};
    vecs[4] = '{2,    20,   0,  0,  28,  1'b1};
    vecs[5] = '{1,    1,    0,  0,  8,   1'b0};
    vecs[6] = '{6,    30,   50, 0,  -1,  1'b0};
    vecs[7] = '{5,    25,   0,  40, -1,  1'b0};

    repeat (3) @(posedge clk_500MHz);
    #1;
    @(negedge clk_500MHz);
    chk("reset_outputs", {8'h0, outs}, 32'h0);
    @(posedge clk_500MHz); #1;
    rst = 1'b0;
    @(negedge clk_500MHz);
    chk("idle_outputs", {8'h0, outs}, 32'h0);

    for (int v = 0; v < 8; v++)
      run_load(vecs[v].n_seq, vecs[v].n_pix, vecs[v].bp, vecs[v].bub,
               vecs[v].exp_done, vecs[v].start_in_pix, 0);

    // Mixed backpressure and bubbles together
    run_load(7, 40, 50, 30, -1, 1'b0, 0);
    // Reset after 40 pixels, then a clean full load
    run_load(4, 100, 0, 0, -1, 1'b0, 40);
    run_load(8, 100, 0, 0, 114, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
